// File: rtl/color_centroid_tracker.sv
// Colour-window centroid tracker for a 16-bit RGB565 pixel stream.
// Accumulates match count and coordinate sums per frame, then divides
// sum/count with a serial restoring divider to produce the centroid.
//
// Accumulation FSM
//   state    | meaning
//   WAIT_SOF | ignore beats until a start-of-frame beat arrives
//   ACCUM    | classify and accumulate pixels of the current frame
//
// Divider FSM
//   state    | meaning
//   IDLE     | waiting for a frame-end snapshot
//   DIV_X    | one quotient bit per cycle of sum_x / count
//   DIV_Y    | one quotient bit per cycle of sum_y / count
//   DONE     | publish results and pulse CENT_VALID
module color_centroid_tracker #(
  parameter int FRAME_W    = 320,
  parameter int FRAME_H    = 240,
  parameter int SUM_W      = 25,
  parameter int MIN_PIXELS = 16
) (
  input  logic        FSM_CLK,
  input  logic        RESETN,
  input  logic [31:0] S_TDATA,
  input  logic        S_TVALID,
  input  logic        S_TUSER,
  input  logic        S_TLAST,
  output logic        S_TREADY,
  input  logic [4:0]  R_MIN,
  input  logic [4:0]  R_MAX,
  input  logic [5:0]  G_MIN,
  input  logic [5:0]  G_MAX,
  input  logic [4:0]  B_MIN,
  input  logic [4:0]  B_MAX,
  output logic [8:0]  CENT_X,
  output logic [7:0]  CENT_Y,
  output logic [16:0] PIX_COUNT,
  output logic        OBJ_FOUND,
  output logic        CENT_VALID,
  output logic        FRAME_ERR
);

  localparam int              BC_W     = $clog2(SUM_W);
  localparam logic [8:0]      X_LAST   = 9'(FRAME_W - 1);
  localparam logic [7:0]      Y_LAST   = 8'(FRAME_H - 1);
  localparam logic [16:0]     MIN_CNT  = 17'(MIN_PIXELS);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(SUM_W - 1);

  typedef enum logic {WAIT_SOF, ACCUM} acc_state_t;
  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} div_state_t;

  acc_state_t acc_state, acc_next;
  div_state_t div_state, div_next;

  logic [8:0]       x, pix_x;
  logic [7:0]       y, pix_y;
  logic [16:0]      cnt, cnt_nxt;
  logic [SUM_W-1:0] sum_x, sum_y, sx_nxt, sy_nxt;

  logic [16:0]      divisor;
  logic [SUM_W-1:0] sy_hold, rem, quo, rem_new, quo_new;
  logic [SUM_W:0]   rem_sh, dvs_ext;
  logic [BC_W-1:0]  bit_cnt;
  logic [8:0]       qx;
  logic             obj_hit, ge;

  logic [4:0] r, b;
  logic [5:0] g;
  logic accept, active, match, frame_end, start_div;
  logic restart_err, row_err, drop_err;
  logic unused_hi;

  assign unused_hi = ^S_TDATA[31:16];
  assign r = S_TDATA[15:11];
  assign g = S_TDATA[10:5];
  assign b = S_TDATA[4:0];

  // An inverted window (MIN > MAX) can never satisfy both bounds, so it matches nothing.
  assign match = (r >= R_MIN) && (r <= R_MAX) && (g >= G_MIN) && (g <= G_MAX) &&
                 (b >= B_MIN) && (b <= B_MAX);

  assign accept = S_TVALID && S_TREADY;
  assign active = accept && (S_TUSER || (acc_state == ACCUM));

  // A start-of-frame beat is pixel (0,0) of a fresh frame regardless of prior state.
  assign pix_x  = S_TUSER ? '0 : x;
  assign pix_y  = S_TUSER ? '0 : y;
  assign cnt_nxt = (S_TUSER ? '0 : cnt) + 17'(match);
  assign sx_nxt  = (S_TUSER ? '0 : sum_x) + (match ? SUM_W'(pix_x) : '0);
  assign sy_nxt  = (S_TUSER ? '0 : sum_y) + (match ? SUM_W'(pix_y) : '0);

  assign frame_end   = active && S_TLAST && (pix_y == Y_LAST);
  assign start_div   = frame_end && (div_state == IDLE);
  assign drop_err    = frame_end && (div_state != IDLE);
  assign restart_err = accept && S_TUSER && (acc_state == ACCUM);
  assign row_err     = active && !S_TLAST && (pix_x == X_LAST);

  // Restoring division step: shift in the next dividend bit, subtract if it fits.
  assign rem_sh  = {rem, quo[SUM_W-1]};
  assign dvs_ext = (SUM_W+1)'(divisor);
  assign ge      = rem_sh >= dvs_ext;
  assign rem_new = ge ? SUM_W'(rem_sh - dvs_ext) : rem_sh[SUM_W-1:0];
  assign quo_new = {quo[SUM_W-2:0], ge};

  // Ready is a register so it reads 0 while in reset and 1 afterwards.
  always_ff @(posedge FSM_CLK or negedge RESETN) begin
    if (!RESETN) S_TREADY <= 1'b0;
    else         S_TREADY <= 1'b1;
  end

  // State registers for both FSMs.
  always_ff @(posedge FSM_CLK or negedge RESETN) begin
    if (!RESETN) begin
      acc_state <= WAIT_SOF;
      div_state <= IDLE;
    end else begin
      acc_state <= acc_next;
      div_state <= div_next;
    end
  end

  // Accumulation next state: frame end returns to WAIT_SOF, any other active beat stays in ACCUM.
  always_comb begin
    acc_next = acc_state;
    if (active) acc_next = frame_end ? WAIT_SOF : ACCUM;
  end

  // Divider next state: too few matches skips the division entirely.
  always_comb begin
    div_next = div_state;
    case (div_state)
      IDLE:    if (start_div) div_next = (cnt_nxt < MIN_CNT) ? DONE : DIV_X;
      DIV_X:   if (bit_cnt == '0) div_next = DIV_Y;
      DIV_Y:   if (bit_cnt == '0) div_next = DONE;
      DONE:    div_next = IDLE;
      default: div_next = IDLE;
    endcase
  end

  // Pixel position and per-frame accumulators; x saturates on the last column.
  always_ff @(posedge FSM_CLK or negedge RESETN) begin
    if (!RESETN) begin
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
      sum_x <= '0;
      sum_y <= '0;
    end else if (active) begin
      cnt   <= cnt_nxt;
      sum_x <= sx_nxt;
      sum_y <= sy_nxt;
      if (S_TLAST) begin
        x <= '0;
        y <= pix_y + 8'd1;
      end else begin
        x <= (pix_x == X_LAST) ? X_LAST : pix_x + 9'd1;
        y <= pix_y;
      end
    end
  end

  // Divider datapath: snapshot at frame end, then x quotient followed by y quotient.
  always_ff @(posedge FSM_CLK or negedge RESETN) begin
    if (!RESETN) begin
      divisor <= '0;
      sy_hold <= '0;
      rem     <= '0;
      quo     <= '0;
      bit_cnt <= '0;
      qx      <= '0;
      obj_hit <= 1'b0;
    end else begin
      case (div_state)
        IDLE: if (start_div) begin
          divisor <= cnt_nxt;
          sy_hold <= sy_nxt;
          rem     <= '0;
          quo     <= sx_nxt;
          bit_cnt <= BIT_LAST;
          obj_hit <= cnt_nxt >= MIN_CNT;
        end
        DIV_X: if (bit_cnt == '0) begin
          qx      <= quo_new[8:0];
          rem     <= '0;
          quo     <= sy_hold;
          bit_cnt <= BIT_LAST;
        end else begin
          rem     <= rem_new;
          quo     <= quo_new;
          bit_cnt <= bit_cnt - 1'b1;
        end
        DIV_Y: begin
          rem     <= rem_new;
          quo     <= quo_new;
          bit_cnt <= bit_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Published results change only in DONE; the centroid holds when no object was found.
  always_ff @(posedge FSM_CLK or negedge RESETN) begin
    if (!RESETN) begin
      CENT_X     <= '0;
      CENT_Y     <= '0;
      PIX_COUNT  <= '0;
      OBJ_FOUND  <= 1'b0;
      CENT_VALID <= 1'b0;
    end else begin
      CENT_VALID <= (div_state == DONE);
      if (div_state == DONE) begin
        PIX_COUNT <= divisor;
        OBJ_FOUND <= obj_hit;
        if (obj_hit) begin
          CENT_X <= qx;
          CENT_Y <= quo[7:0];
        end
      end
    end
  end

  // Sticky stream error: restarted frame, overlong row, or frame end while dividing.
  always_ff @(posedge FSM_CLK or negedge RESETN) begin
    if (!RESETN)                               FRAME_ERR <= 1'b0;
    else if (restart_err || row_err || drop_err) FRAME_ERR <= 1'b1;
  end

endmodule

// File: tb/tb_color_centroid_tracker.sv
// Randomised bench for color_centroid_tracker on a reduced 40x30 frame.
// Two instances share the stream: one with the default object threshold
// and one with a threshold of 1, so every frame is judged both ways.
module tb_color_centroid_tracker;

  localparam int FW = 40;
  localparam int FH = 30;
  localparam int SW = 25;

  typedef struct {
    int cnt;
    int found;
    int cx;
    int cy;
    int when;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tdata;
  logic        tvalid, tuser, tlast;
  logic [4:0]  r_min, r_max, b_min, b_max;
  logic [5:0]  g_min, g_max;

  logic        tready0, tready1;
  logic [8:0]  cent_x0, cent_x1;
  logic [7:0]  cent_y0, cent_y1;
  logic [16:0] pix_count0, pix_count1;
  logic        obj_found0, obj_found1, cent_valid0, cent_valid1, frame_err0, frame_err1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] pix [0:FH-1][0:FW-1];
  exp_t q0[$];
  exp_t q1[$];
  int   minp [2] = '{16, 1};
  int   last_cx [2] = '{0, 0};
  int   last_cy [2] = '{0, 0};
  int   ferr_exp = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  color_centroid_tracker #(.FRAME_W(FW), .FRAME_H(FH), .SUM_W(SW), .MIN_PIXELS(16)) u_dut0 (
    .FSM_CLK(clk), .RESETN(rst_n), .S_TDATA(tdata), .S_TVALID(tvalid), .S_TUSER(tuser),
    .S_TLAST(tlast), .S_TREADY(tready0), .R_MIN(r_min), .R_MAX(r_max), .G_MIN(g_min),
    .G_MAX(g_max), .B_MIN(b_min), .B_MAX(b_max), .CENT_X(cent_x0), .CENT_Y(cent_y0),
    .PIX_COUNT(pix_count0), .OBJ_FOUND(obj_found0), .CENT_VALID(cent_valid0),
    .FRAME_ERR(frame_err0));

  color_centroid_tracker #(.FRAME_W(FW), .FRAME_H(FH), .SUM_W(SW), .MIN_PIXELS(1)) u_dut1 (
    .FSM_CLK(clk), .RESETN(rst_n), .S_TDATA(tdata), .S_TVALID(tvalid), .S_TUSER(tuser),
    .S_TLAST(tlast), .S_TREADY(tready1), .R_MIN(r_min), .R_MAX(r_max), .G_MIN(g_min),
    .G_MAX(g_max), .B_MIN(b_min), .B_MAX(b_max), .CENT_X(cent_x1), .CENT_Y(cent_y1),
    .PIX_COUNT(pix_count1), .OBJ_FOUND(obj_found1), .CENT_VALID(cent_valid1),
    .FRAME_ERR(frame_err1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] rgb(input int r, input int g, input int b);
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  function automatic bit in_win(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    return (r >= int'(r_min)) && (r <= int'(r_max)) && (g >= int'(g_min)) &&
           (g <= int'(g_max)) && (b >= int'(b_min)) && (b <= int'(b_max));
  endfunction

  task automatic set_win(input int r0, input int r1, input int g0, input int g1,
                         input int b0, input int b1);
    r_min = 5'(r0); r_max = 5'(r1);
    g_min = 6'(g0); g_max = 6'(g1);
    b_min = 5'(b0); b_max = 5'(b1);
  endtask

  task automatic fill_bg(input logic [15:0] v);
    for (int yy = 0; yy < FH; yy++)
      for (int xx = 0; xx < FW; xx++)
        pix[yy][xx] = v;
  endtask

  // Reference: centroid is the floor of mean x/y over matching pixels.
  task automatic model_frame_end(input int e);
    int cnt, sx, sy;
    exp_t ex;
    cnt = 0; sx = 0; sy = 0;
    for (int yy = 0; yy < FH; yy++)
      for (int xx = 0; xx < FW; xx++)
        if (in_win(pix[yy][xx])) begin
          cnt++;
          sx += xx;
          sy += yy;
        end
    for (int d = 0; d < 2; d++) begin
      ex.cnt   = cnt;
      ex.found = (cnt >= minp[d]) ? 1 : 0;
      if (ex.found == 1) begin
        last_cx[d] = sx / cnt;
        last_cy[d] = sy / cnt;
      end
      ex.cx   = last_cx[d];
      ex.cy   = last_cy[d];
      ex.when = e + ((ex.found == 1) ? (2 * SW + 1) : 1);
      if (d == 0) q0.push_back(ex);
      else        q1.push_back(ex);
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic u, input logic l, input bit gaps);
    logic [31:0] rnd;
    if (gaps && ($urandom_range(0, 7) == 0)) begin
      tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    rnd    = $urandom();
    tdata  = {rnd[15:0], d};
    tvalid = 1'b1;
    tuser  = u;
    tlast  = l;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_frame(input int lines, input bit gaps);
    for (int yy = 0; yy < lines; yy++)
      for (int xx = 0; xx < FW; xx++)
        beat(pix[yy][xx], (xx == 0) && (yy == 0), xx == FW - 1, gaps);
    if (lines == FH) model_frame_end(cyc);
  endtask

  task automatic send_garbage(input int n);
    logic [31:0] rnd;
    for (int i = 0; i < n; i++) begin
      rnd = $urandom();
      beat(rnd[15:0], 1'b0, (i % FW) == FW - 1, 1'b0);
    end
  endtask

  task automatic wait_result(input string tag);
    repeat (2 * SW + 10) @(posedge clk);
    #1;
    check({tag, "_pending0"}, q0.size(), 0);
    check({tag, "_pending1"}, q1.size(), 0);
    check({tag, "_ferr0"}, frame_err0, ferr_exp);
    check({tag, "_ferr1"}, frame_err1, ferr_exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, {tready1, tready0}, 0);
    check({tag, "_cx"}, {cent_x1, cent_x0}, 0);
    check({tag, "_cy"}, {cent_y1, cent_y0}, 0);
    check({tag, "_cnt"}, {pix_count1, pix_count0}, 0);
    check({tag, "_flags"}, {obj_found1, cent_valid1, frame_err1, obj_found0, cent_valid0, frame_err0}, 0);
  endtask

  task automatic block_frame(input int n);
    int k;
    set_win(28, 31, 0, 63, 0, 31);
    fill_bg(16'h0000);
    k = 0;
    for (int yy = 5; yy <= 8; yy++)
      for (int xx = 10; xx <= 13; xx++) begin
        if (k < n) pix[yy][xx] = 16'hF800;
        k++;
      end
  endtask

  task automatic random_frame();
    int r0, r1, g0, g1, b0, b1, k;
    logic [31:0] rnd;
    r0 = $urandom_range(0, 20); r1 = r0 + $urandom_range(0, 11);
    g0 = $urandom_range(0, 40); g1 = g0 + $urandom_range(0, 23);
    b0 = $urandom_range(0, 20); b1 = b0 + $urandom_range(0, 11);
    set_win(r0, r1, g0, g1, b0, b1);
    case ($urandom_range(0, 2))
      0:       k = 4;
      1:       k = 64;
      default: k = 100;
    endcase
    for (int yy = 0; yy < FH; yy++)
      for (int xx = 0; xx < FW; xx++) begin
        rnd = $urandom();
        if ($urandom_range(1, k) == 1)
          pix[yy][xx] = rgb($urandom_range(r0, r1), $urandom_range(g0, g1), $urandom_range(b0, b1));
        else
          pix[yy][xx] = rnd[15:0];
      end
  endtask

  task automatic mon(input int d, input logic v, input logic [16:0] pc, input logic f,
                     input logic [8:0] cx, input logic [7:0] cy);
    exp_t e;
    int sz;
    if (v === 1'b1) begin
      sz = (d == 0) ? q0.size() : q1.size();
      check($sformatf("valid_expected%0d", d), sz > 0, 1);
      if (sz > 0) begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("latency%0d", d), cyc, e.when);
        check($sformatf("pix_count%0d", d), pc, e.cnt);
        check($sformatf("obj_found%0d", d), f, e.found);
        check($sformatf("cent_x%0d", d), cx, e.cx);
        check($sformatf("cent_y%0d", d), cy, e.cy);
      end
    end
  endtask

  // Results are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, cent_valid0, pix_count0, obj_found0, cent_x0, cent_y0);
    mon(1, cent_valid1, pix_count1, obj_found1, cent_x1, cent_y1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int px, py;
    rst_n = 1'b0;
    tdata = '0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    set_win(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", {tready1, tready0}, 2'b11);

    // Beats before the first start-of-frame are ignored.
    send_garbage(2 * FW + 7);

    block_frame(16);
    send_frame(FH, 1'b0);
    wait_result("block16");

    block_frame(15);
    send_frame(FH, 1'b0);
    wait_result("block15");

    set_win(28, 31, 0, 63, 0, 31);
    fill_bg(16'h0000);
    pix[FH-1][FW-1] = 16'hF800;
    send_frame(FH, 1'b0);
    wait_result("corner");

    // Window boundaries, one candidate pixel per frame.
    for (int t = 0; t < 4; t++) begin
      fill_bg(16'h0000);
      px = $urandom_range(0, FW - 1);
      py = $urandom_range(0, FH - 1);
      case (t)
        0: begin set_win(10, 20, 0, 63, 0, 31); pix[py][px] = rgb(20, 0, 0); end
        1: begin set_win(10, 20, 0, 63, 0, 31); pix[py][px] = rgb(21, 0, 0); end
        2: begin set_win(10, 20, 5, 40, 0, 31); pix[py][px] = rgb(15, 4, 0); end
        default: begin set_win(10, 20, 5, 40, 0, 31); pix[py][px] = rgb(10, 5, 0); end
      endcase
      send_frame(FH, 1'b0);
      wait_result($sformatf("bound%0d", t));
    end

    // Inverted red window matches nothing.
    set_win(20, 10, 0, 63, 0, 31);
    fill_bg(rgb(15, 30, 15));
    send_frame(FH, 1'b0);
    wait_result("inverted");

    for (int i = 0; i < 6; i++) begin
      random_frame();
      send_frame(FH, 1'b1);
      wait_result($sformatf("rand%0d", i));
    end

    // Restart mid-frame: partial frame discarded, error sticks, next frame is good.
    random_frame();
    send_frame(10, 1'b1);
    ferr_exp = 1;
    random_frame();
    send_frame(FH, 1'b1);
    wait_result("restart");
    random_frame();
    send_frame(FH, 1'b0);
    wait_result("after_restart");

    // Reset in the middle of the x division aborts it.
    block_frame(16);
    send_frame(FH, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("mid_div_reset");
    q0.delete();
    q1.delete();
    last_cx = '{0, 0};
    last_cy = '{0, 0};
    ferr_exp = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_result("post_reset_idle");
    send_garbage(3 * FW + 5);
    wait_result("post_reset_garbage");
    block_frame(15);
    send_frame(FH, 1'b0);
    wait_result("post_reset_frame");
    random_frame();
    send_frame(FH, 1'b1);
    wait_result("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/color_centroid_tracker.md
Name: color_centroid_tracker

Overview:
- Consumes the 16-bit-pixel camera stream produced by the OV7670 capture stage: data, valid, ready, start-of-frame on the first pixel, end-of-line on the last pixel of each row.
- Classifies each RGB565 pixel against a runtime colour window and accumulates match count, sum of x and sum of y over each frame.
- At frame end, computes the integer centroid of matching pixels with an iterative divider.
- Feeds the game's player-position logic.

Parameters:
- FRAME_W, 320, pixels per line.
- FRAME_H, 240, lines per frame.
- SUM_W, 25, width of the coordinate-sum accumulators and of the divider; must hold FRAME_W*FRAME_H*(FRAME_W-1).
- MIN_PIXELS, 16, minimum match count for a valid object.

Ports:
- FSM_CLK  in  1  Sole clock.
- RESETN  in  1  Asynchronous, active-low reset.
- S_TDATA  in  32  Pixel; [15:0] = RGB565 (R=[15:11], G=[10:5], B=[4:0]); [31:16] ignored.
- S_TVALID  in  1  Beat valid.
- S_TUSER  in  1  Start of frame, marks pixel (0,0).
- S_TLAST  in  1  End of line, marks the last pixel of a row.
- S_TREADY  out  1  Always 1 out of reset; the block never stalls.
- R_MIN, R_MAX  in  5 each  Inclusive red window.
- G_MIN, G_MAX  in  6 each  Inclusive green window.
- B_MIN, B_MAX  in  5 each  Inclusive blue window.
- CENT_X  out  9  Centroid x.
- CENT_Y  out  8  Centroid y.
- PIX_COUNT  out  17  Match count of the last completed frame.
- OBJ_FOUND  out  1  Last completed frame had at least MIN_PIXELS matches.
- CENT_VALID  out  1  One-cycle pulse when the outputs above update.
- FRAME_ERR  out  1  Sticky; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): every output 0, including S_TREADY. Accumulators and counters cleared. Accumulation FSM goes to WAIT_SOF; divider FSM goes to IDLE.
- A beat is accepted when S_TVALID && S_TREADY.
- A pixel matches when R, G and B all lie within their inclusive [MIN,MAX] windows. If MIN > MAX for any channel, nothing matches.

Accumulation FSM:
- WAIT_SOF: accepted beats without S_TUSER are ignored. A beat with S_TUSER goes to ACCUM, processed as pixel (0,0).
- ACCUM, on any S_TUSER beat:
  - Set x=0, y=0 and clear sums and count before adding this pixel.
  - If the previous frame was incomplete, set FRAME_ERR and discard that frame; no CENT_VALID for it.
- ACCUM, on each accepted beat: if the pixel matches, count+=1, sum_x+=x, sum_y+=y. Then x+=1.
  - x saturates at FRAME_W-1. A further beat without S_TLAST sets FRAME_ERR.
- S_TLAST beat: x<=0, y+=1.
- Frame end is the S_TLAST beat with y==FRAME_H-1. On that beat:
  - Snapshot count, sum_x and sum_y, including that beat's contribution, into the divider registers.
  - Return to WAIT_SOF.
- S_TLAST beat with y>FRAME_H-1: impossible by construction, because frame end leaves ACCUM.

Divider FSM (states IDLE, DIV_X, DIV_Y, DONE):
- Started by frame end.
- If snapshot count < MIN_PIXELS:
  - Go straight to DONE; CENT_VALID pulses on the next edge.
  - OBJ_FOUND=0, PIX_COUNT=count; CENT_X/CENT_Y hold their previous values.
- Otherwise:
  - DIV_X runs SUM_W restoring-division iterations, sum_x/count, one quotient bit per cycle. DIV_Y then does the same for sum_y/count.
  - DONE drives CENT_X/CENT_Y from the low quotient bits (floor), PIX_COUNT=count, OBJ_FOUND=1, and pulses CENT_VALID for one cycle.
  - CENT_VALID is high in the cycle after edge E+2*SUM_W+1, where E is the edge that accepted the frame-end beat (51 edges for the defaults).
- Outputs are registered and change only at DONE.
- A frame end arriving while the divider is not IDLE: drop the new snapshot, set FRAME_ERR, and let the current division finish unaffected.
- Accumulation of the next frame continues in parallel with division.
- Reset mid-division aborts it: outputs go to 0 and no CENT_VALID is produced.

Test Plan:
- Full 320x240 frame, only a 4x4 block at x=100..103, y=50..53 matching (0xF800 with R_MIN=28, others full range) -> 51 edges after the last beat: CENT_VALID one cycle, PIX_COUNT=16, CENT_X=101, CENT_Y=51, OBJ_FOUND=1, FRAME_ERR=0.
- Same frame with 15 matching pixels -> CENT_VALID one edge after frame end, OBJ_FOUND=0, PIX_COUNT=15, CENT_X/Y unchanged from the previous frame.
- MIN_PIXELS=1, only pixel (319,239) matches -> CENT_X=319, CENT_Y=239; PIX_COUNT=1.
- Boundaries: R=R_MAX matches, R=R_MAX+1 does not; G=G_MIN-1 does not. Verify via PIX_COUNT on frames with exactly one such pixel each.
- S_TUSER arriving at y=100 mid-frame -> FRAME_ERR=1 stays set. No CENT_VALID for the partial frame. The following complete frame reports correct values.
- RESETN pulsed low during DIV_X -> all outputs 0 immediately. Beats before the next S_TUSER are ignored. No CENT_VALID until a full subsequent frame completes.
